// File: rtl/bp_be_pkg.sv
// rtl/bp_be_pkg.sv - shared types for the BE stride prefetch scheduler
`ifndef BP_BE_PKG_SV
`define BP_BE_PKG_SV

`define BP_BE_PF_EVENT_S(vaddr_w, stride_w) \
  struct packed { \
    logic [vaddr_w-1:0]  pc; \
    logic [vaddr_w-1:0]  eff_addr; \
    logic [stride_w-1:0] stride; \
  }

package bp_be_pkg;

  typedef enum logic {
    e_pf_idle  = 1'b0,
    e_pf_issue = 1'b1
  } bp_be_pf_state_e;

endpackage

`endif

// File: rtl/bp_be_pf_event_fifo.sv
// rtl/bp_be_pf_event_fifo.sv - 1r1w ring FIFO of stride events, wrap-around pointers plus count
module bp_be_pf_event_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clr_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               yumi_i,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  output logic               full_o
);
  localparam int ptr_w_lp = $clog2(els_p);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [ptr_w_lp:0]   cnt_q, cnt_d;
  logic                push, pop;

  assign full_o = (cnt_q == (ptr_w_lp+1)'(els_p));
  assign v_o    = (cnt_q != '0);
  assign data_o = mem_q[rptr_q];

  // Fullness is judged on the start-of-cycle count, so a same-cycle pop never frees room
  always_comb begin
    push   = v_i & ~full_o & ~clr_i;
    pop    = yumi_i & v_o & ~clr_i;
    rptr_d = rptr_q + ptr_w_lp'(pop);
    wptr_d = wptr_q + ptr_w_lp'(push);
    cnt_d  = cnt_q + (ptr_w_lp+1)'(push) - (ptr_w_lp+1)'(pop);
    if (clr_i) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/bp_be_pf_scheduler.sv
// rtl/bp_be_pf_scheduler.sv - queues stride events and issues pf_degree_p page-bounded prefetches each
// Perf counters are built only when BP_BE_PF_PERF_EN is defined; otherwise the counter ports read 0.
module bp_be_pf_scheduler
  import bp_be_pkg::*;
#(
  parameter int vaddr_width_p      = 39,
  parameter int stride_width_p     = 8,
  parameter int fifo_els_p         = 4,
  parameter int pf_degree_p        = 4,
  parameter int page_offset_bits_p = 12
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      enable_i,
  input  logic                      flush_i,
  input  logic                      rpt_v_i,
  input  logic [vaddr_width_p-1:0]  rpt_pc_i,
  input  logic [vaddr_width_p-1:0]  rpt_eff_addr_i,
  input  logic [stride_width_p-1:0] rpt_stride_i,
  input  logic                      demand_v_i,
  output logic                      pf_v_o,
  output logic [vaddr_width_p-1:0]  pf_vaddr_o,
  input  logic                      pf_ready_i,
  output logic                      busy_o,
  output logic [15:0]               pf_issued_o,
  output logic [15:0]               pf_dropped_o,
  output logic [15:0]               pf_aborted_o
);
  typedef `BP_BE_PF_EVENT_S(vaddr_width_p, stride_width_p) pf_event_s;
  localparam int cnt_w_lp = $clog2(pf_degree_p + 1);

  function automatic logic [vaddr_width_p-1:0] sext(input logic [stride_width_p-1:0] s);
    return {{(vaddr_width_p-stride_width_p){s[stride_width_p-1]}}, s};
  endfunction

  function automatic logic same_page(input logic [vaddr_width_p-1:0] a, input logic [vaddr_width_p-1:0] b);
    return a[vaddr_width_p-1:page_offset_bits_p] == b[vaddr_width_p-1:page_offset_bits_p];
  endfunction

  bp_be_pf_state_e             state_q, state_d;
  logic [vaddr_width_p-1:0]    addr_q, addr_d, cur_pc_q, cur_pc_d;
  logic [stride_width_p-1:0]   stride_q, stride_d;
  logic [cnt_w_lp-1:0]         cnt_q, cnt_d;

  pf_event_s                   fifo_wdata, fifo_head;
  logic                        fifo_v, fifo_full, fifo_pop;
  logic                        rpt_ok, restart, enq_req, drop_inc, abort_inc, hs;
  logic [vaddr_width_p-1:0]    head_nxt, rst_nxt, step_nxt;

  bp_be_pf_event_fifo #(
    .width_p ($bits(pf_event_s)),
    .els_p   (fifo_els_p)
  ) event_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clr_i     (flush_i),
    .v_i       (enq_req),
    .data_i    (fifo_wdata),
    .yumi_i    (fifo_pop),
    .data_o    (fifo_head),
    .v_o       (fifo_v),
    .full_o    (fifo_full)
  );

  assign pf_v_o     = (state_q == e_pf_issue) & enable_i & ~demand_v_i & ~flush_i;
  assign pf_vaddr_o = addr_q;
  assign busy_o     = fifo_v | (state_q != e_pf_idle);
  assign hs         = pf_v_o & pf_ready_i;

  always_comb begin
    rpt_ok     = rpt_v_i & enable_i & ~flush_i & (rpt_stride_i != '0);
    restart    = rpt_ok & (state_q == e_pf_issue) & (rpt_pc_i == cur_pc_q);
    enq_req    = rpt_ok & ~restart;
    drop_inc   = enq_req & fifo_full;
    fifo_wdata = '{pc: rpt_pc_i, eff_addr: rpt_eff_addr_i, stride: rpt_stride_i};
    fifo_pop   = (state_q == e_pf_idle) & fifo_v & enable_i & ~flush_i;
    head_nxt   = fifo_head.eff_addr + sext(fifo_head.stride);
    rst_nxt    = rpt_eff_addr_i + sext(rpt_stride_i);
    step_nxt   = addr_q + sext(stride_q);

    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    cur_pc_d  = cur_pc_q;
    stride_d  = stride_q;
    abort_inc = 1'b0;

    if (flush_i) begin
      state_d = e_pf_idle;
    end else begin
      case (state_q)
        e_pf_idle: begin
          if (fifo_pop) begin
            if (!same_page(head_nxt, fifo_head.eff_addr)) begin
              abort_inc = 1'b1;
            end else begin
              addr_d   = head_nxt;
              cnt_d    = '0;
              cur_pc_d = fifo_head.pc;
              stride_d = fifo_head.stride;
              state_d  = e_pf_issue;
            end
          end
        end
        e_pf_issue: begin
          // A same-pc report retargets the live stream; its own handshake is still counted
          if (restart) begin
            if (!same_page(rst_nxt, rpt_eff_addr_i)) begin
              abort_inc = 1'b1;
              state_d   = e_pf_idle;
            end else begin
              addr_d   = rst_nxt;
              stride_d = rpt_stride_i;
              cnt_d    = '0;
            end
          end else if (hs) begin
            if (cnt_q == cnt_w_lp'(pf_degree_p - 1)) begin
              state_d = e_pf_idle;
            end else if (!same_page(step_nxt, addr_q)) begin
              abort_inc = 1'b1;
              state_d   = e_pf_idle;
            end else begin
              addr_d = step_nxt;
              cnt_d  = cnt_q + cnt_w_lp'(1);
            end
          end
        end
        default: state_d = e_pf_idle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= e_pf_idle;
      addr_q   <= '0;
      cnt_q    <= '0;
      cur_pc_q <= '0;
      stride_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      cur_pc_q <= cur_pc_d;
      stride_q <= stride_d;
    end
  end

`ifdef BP_BE_PF_PERF_EN
  logic [15:0] issued_q, issued_d, dropped_q, dropped_d, aborted_q, aborted_d;

  always_comb begin
    issued_d  = issued_q  + 16'(hs        & (issued_q  != 16'hFFFF));
    dropped_d = dropped_q + 16'(drop_inc  & (dropped_q != 16'hFFFF));
    aborted_d = aborted_q + 16'(abort_inc & (aborted_q != 16'hFFFF));
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      issued_q  <= '0;
      dropped_q <= '0;
      aborted_q <= '0;
    end else begin
      issued_q  <= issued_d;
      dropped_q <= dropped_d;
      aborted_q <= aborted_d;
    end
  end

  assign pf_issued_o  = issued_q;
  assign pf_dropped_o = dropped_q;
  assign pf_aborted_o = aborted_q;
`else
  logic unused_perf;
  assign unused_perf  = ^{drop_inc, abort_inc};
  assign pf_issued_o  = '0;
  assign pf_dropped_o = '0;
  assign pf_aborted_o = '0;
`endif

endmodule

// File: tb/tb_bp_be_pf_scheduler.sv
// tb/tb_bp_be_pf_scheduler.sv - randomized and directed self-checking bench for bp_be_pf_scheduler
module tb_bp_be_pf_scheduler;
  localparam int V = 39, S = 8, ELS = 4, DEG = 4, PB = 12;

  logic clk = 1'b0, rst_n = 1'b0;
  logic enable, flush, rpt_v, demand, pf_ready;
  logic [V-1:0] rpt_pc, rpt_ea;
  logic [S-1:0] rpt_st;
  logic pf_v_o, busy_o;
  logic [V-1:0] pf_vaddr_o;
  logic [15:0] pf_issued_o, pf_dropped_o, pf_aborted_o;

  bp_be_pf_scheduler dut (
    .clk_i(clk), .reset_n_i(rst_n), .enable_i(enable), .flush_i(flush),
    .rpt_v_i(rpt_v), .rpt_pc_i(rpt_pc), .rpt_eff_addr_i(rpt_ea), .rpt_stride_i(rpt_st),
    .demand_v_i(demand), .pf_v_o(pf_v_o), .pf_vaddr_o(pf_vaddr_o), .pf_ready_i(pf_ready),
    .busy_o(busy_o), .pf_issued_o(pf_issued_o), .pf_dropped_o(pf_dropped_o), .pf_aborted_o(pf_aborted_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [V-1:0] pc;
    logic [V-1:0] base;
    int           stride;
  } ev_t;

  int n_tests = 0, n_fail = 0;
  ev_t q[$];
  bit m_active;
  ev_t m_cur;
  int m_k;
  int m_issued, m_dropped, m_aborted;
  longint cyc = 0;
  logic [V-1:0] log_q[$];
  longint logc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [V-1:0] addr_at(input logic [V-1:0] base, input int stride, input int k);
    longint d;
    logic [63:0] dv;
    d  = longint'(k) * longint'(stride);
    dv = d;
    return base + dv[V-1:0];
  endfunction

  function automatic logic [V-PB-1:0] page(input logic [V-1:0] a);
    return a[V-1:PB];
  endfunction

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic start_stream(input ev_t e);
    if (page(addr_at(e.base, e.stride, 1)) != page(e.base)) begin
      m_aborted = sat(m_aborted + 1);
      m_active  = 1'b0;
    end else begin
      m_active = 1'b1;
      m_cur    = e;
      m_k      = 1;
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_active  = 1'b0;
    m_k       = 0;
    m_issued  = 0;
    m_dropped = 0;
    m_aborted = 0;
  endtask

  task automatic check_counters();
`ifdef BP_BE_PF_PERF_EN
    check("pf_issued", pf_issued_o, 64'(m_issued));
    check("pf_dropped", pf_dropped_o, 64'(m_dropped));
    check("pf_aborted", pf_aborted_o, 64'(m_aborted));
`else
    check("pf_issued", pf_issued_o, 64'd0);
    check("pf_dropped", pf_dropped_o, 64'd0);
    check("pf_aborted", pf_aborted_o, 64'd0);
`endif
  endtask

  // Compare the DUT against the model for this cycle's inputs, then advance the model across the edge
  task automatic step();
    bit exp_v, hs, rok, rs, enq;
    int sz0;
    ev_t e, ne;
    #1;
    exp_v = m_active & enable & ~demand & ~flush;
    check("pf_v", pf_v_o, exp_v);
    if (exp_v) check("pf_vaddr", pf_vaddr_o, addr_at(m_cur.base, m_cur.stride, m_k));
    check("busy", busy_o, (q.size() != 0) || m_active);
    check_counters();
    if (pf_v_o && pf_ready) begin
      log_q.push_back(pf_vaddr_o);
      logc_q.push_back(cyc);
    end
    hs = exp_v & pf_ready;
    if (flush) begin
      q.delete();
      m_active = 1'b0;
    end else begin
      sz0 = q.size();
      ne.pc = rpt_pc;
      ne.base = rpt_ea;
      ne.stride = int'($signed(rpt_st));
      rok = rpt_v & enable & (rpt_st != '0);
      rs  = rok & m_active & (rpt_pc == m_cur.pc);
      enq = rok & ~rs;
      if (m_active) begin
        if (hs) m_issued = sat(m_issued + 1);
        if (rs) start_stream(ne);
        else if (hs) begin
          if (m_k == DEG) m_active = 1'b0;
          else if (page(addr_at(m_cur.base, m_cur.stride, m_k + 1)) != page(m_cur.base)) begin
            m_aborted = sat(m_aborted + 1);
            m_active  = 1'b0;
          end else m_k++;
        end
      end else if (enable && sz0 > 0) begin
        e = q.pop_front();
        start_stream(e);
      end
      if (enq) begin
        if (sz0 < ELS) q.push_back(ne);
        else m_dropped = sat(m_dropped + 1);
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic quiet();
    enable = 1'b1; flush = 1'b0; rpt_v = 1'b0; demand = 1'b0;
    rpt_pc = '0; rpt_ea = '0; rpt_st = '0;
  endtask

  task automatic report(input logic [V-1:0] pc, input logic [V-1:0] ea, input logic [S-1:0] st);
    rpt_v = 1'b1; rpt_pc = pc; rpt_ea = ea; rpt_st = st;
    step();
    rpt_v = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_log(input string name, input logic [V-1:0] exp[$]);
    check({name, "_len"}, 64'(log_q.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < log_q.size(); i++)
      check(name, log_q[i], exp[i]);
  endtask

  initial begin
    logic [V-1:0] exp[$];
    logic [V-1:0] pcs[3];
    logic [63:0] r;
    longint c0;
    int b0;
    pcs[0] = 39'h100; pcs[1] = 39'h200; pcs[2] = 39'h300;
    quiet();
    pf_ready = 1'b1;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_pf_v", pf_v_o, 0);
    check("rst_vaddr", pf_vaddr_o, 0);
    check("rst_busy", busy_o, 0);
    check_counters();
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic +8 stream, first request two cycles after the report
    log_q.delete(); logc_q.delete(); b0 = m_issued; c0 = cyc;
    report(39'h100, 39'h1000, 8'h08);
    run(8);
    exp = '{39'h1008, 39'h1010, 39'h1018, 39'h1020};
    check_log("t1", exp);
    if (logc_q.size() == 4) begin
      check("t1_first_lat", 64'(logc_q[0] - c0), 64'd2);
      check("t1_back2back", 64'(logc_q[3] - logc_q[0]), 64'd3);
    end
    check("t1_model_issued", 64'(m_issued - b0), 64'd4);

    // 2: negative stride, then a stream whose first step leaves the page
    log_q.delete();
    report(39'h200, 39'h2040, 8'hF0);
    run(8);
    exp = '{39'h2030, 39'h2020, 39'h2010, 39'h2000};
    check_log("t2", exp);
    log_q.delete(); b0 = m_aborted;
    report(39'h200, 39'h2008, 8'hF0);
    run(4);
    check("t2_no_pf", 64'(log_q.size()), 64'd0);
    check("t2_model_abort", 64'(m_aborted - b0), 64'd1);

    // 3: burst while the cache stalls; one stream active, four queued, rest dropped
    log_q.delete(); b0 = m_dropped;
    pf_ready = 1'b0;
    for (int i = 0; i < 7; i++) report(39'h400 + 39'(i * 16), 39'h4000 + 39'(i * 'h1000), 8'h08);
    check("t3_model_drop", 64'(m_dropped - b0), 64'd2);
    check("t3_model_q", 64'(q.size()), 64'd4);
    pf_ready = 1'b1;
    run(40);
    exp.delete();
    for (int i = 0; i < 5; i++)
      for (int k = 1; k <= 4; k++) exp.push_back(39'h4000 + 39'(i * 'h1000) + 39'(k * 8));
    check_log("t3", exp);

    // 4: demand stalls the stream for three cycles without losing addresses
    log_q.delete(); logc_q.delete();
    report(39'h500, 39'h5000, 8'h10);
    run(3);
    demand = 1'b1;
    run(3);
    demand = 1'b0;
    run(6);
    exp = '{39'h5010, 39'h5020, 39'h5030, 39'h5040};
    check_log("t4", exp);
    if (logc_q.size() == 4) check("t4_gap", 64'(logc_q[2] - logc_q[1]), 64'd4);

    // 5: same-pc report during the second request restarts the stream
    log_q.delete();
    report(39'h100, 39'h1000, 8'h08);
    run(2);
    report(39'h100, 39'h3000, 8'h08);
    run(8);
    exp = '{39'h1008, 39'h1010, 39'h3008, 39'h3010, 39'h3018, 39'h3020};
    check_log("t5", exp);

    // 6: flush with work queued, then asynchronous reset mid-stream
    pf_ready = 1'b0;
    report(39'h600, 39'h6000, 8'h08);
    for (int i = 1; i < 4; i++) report(39'h600 + 39'(i * 16), 39'h6000 + 39'(i * 'h1000), 8'h08);
    check("t6_model_q", 64'(q.size()), 64'd3);
    flush = 1'b1;
    #1;
    check("t6_flush_pf_v", pf_v_o, 0);
    step();
    flush = 1'b0;
    #1;
    check("t6_busy_after_flush", busy_o, 0);
    step();
    report(39'h700, 39'h7000, 8'h08);
    run(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_pf_v", pf_v_o, 0);
    check("t6_rst_vaddr", pf_vaddr_o, 0);
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_cnt", {pf_issued_o, pf_dropped_o, pf_aborted_o}, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    pf_ready = 1'b1;

    // Random traffic: few pcs to provoke restarts, random bases to hit page edges
    for (int i = 0; i < 3000; i++) begin
      r        = {$urandom(), $urandom()};
      enable   = ($urandom_range(0, 9) != 0);
      flush    = ($urandom_range(0, 49) == 0);
      demand   = ($urandom_range(0, 3) == 0);
      pf_ready = ($urandom_range(0, 9) < 7);
      rpt_v    = ($urandom_range(0, 9) < 3);
      rpt_pc   = pcs[$urandom_range(0, 2)];
      rpt_ea   = r[V-1:0];
      rpt_st   = S'($urandom_range(0, 255));
      step();
    end
    quiet();
    run(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
